// File: rtl/logic_arbiter.sv
// rtl/logic_arbiter.sv - two-requester round-robin arbiter in front of a shared 32-bit AND/OR/XOR unit
//
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   req0_valid/ready/s1/s2/op/tag    requester 0: valid/ready handshake, operands, one-hot op, tag
//   req1_valid/ready/s1/s2/op/tag    requester 1: same as requester 0
//   res_valid/ready/data/tag/src     registered result with the winner's tag and source id
//   stat_grant0/1, stat_conflict     saturating 16-bit counters, present only with LOGIC_ARB_STATS_EN
//
// Optional feature macro: LOGIC_ARB_STATS_EN
module logic_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_s1,
    input  logic [XLEN-1:0]  req0_s2,
    input  logic [2:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_s1,
    input  logic [XLEN-1:0]  req1_s2,
    input  logic [2:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_src
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [15:0]      stat_grant0,
    output logic [15:0]      stat_grant1,
    output logic [15:0]      stat_conflict
`endif
);

    logic             last_grant;
    logic             can_accept;
    logic             any_valid;
    logic             grant_sel;
    logic             accept;
    logic [XLEN-1:0]  win_s1;
    logic [XLEN-1:0]  win_s2;
    logic [2:0]       win_op;
    logic [TAG_W-1:0] win_tag;
    logic [XLEN-1:0]  win_result;

    // Lowest set op bit wins, so multi-hot ops resolve AND > OR > XOR.
    function automatic logic [XLEN-1:0] logic_op(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        if (op[0])      return a & b;
        else if (op[1]) return a | b;
        else if (op[2]) return a ^ b;
        else            return '0;
    endfunction

    // A result slot is free when empty or being drained this same cycle.
    assign can_accept = !res_valid || res_ready;
    assign any_valid  = req0_valid || req1_valid;
    // On a conflict the requester that did not win last time goes first.
    assign grant_sel  = (req0_valid && req1_valid) ? !last_grant : req1_valid;

    assign req0_ready = can_accept && any_valid && !grant_sel;
    assign req1_ready = can_accept && any_valid &&  grant_sel;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_comb begin
        win_s1  = req0_s1;
        win_s2  = req0_s2;
        win_op  = req0_op;
        win_tag = req0_tag;
        if (grant_sel) begin
            win_s1  = req1_s1;
            win_s2  = req1_s2;
            win_op  = req1_op;
            win_tag = req1_tag;
        end
        win_result = logic_op(win_op, win_s1, win_s2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_tag    <= '0;
            res_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            res_valid  <= 1'b1;
            res_data   <= win_result;
            res_tag    <= win_tag;
            res_src    <= grant_sel;
            last_grant <= grant_sel;
        end else if (res_valid && res_ready) begin
            // Payload fields are left as-is after a drain.
            res_valid  <= 1'b0;
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (accept && !grant_sel && stat_grant0 != 16'hFFFF)
                stat_grant0 <= stat_grant0 + 16'd1;
            if (accept && grant_sel && stat_grant1 != 16'hFFFF)
                stat_grant1 <= stat_grant1 + 16'd1;
            if (req0_valid && req1_valid && can_accept && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: doc/logic_arbiter.md
Name: logic_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR, one-hot op) between two requesters, e.g. two issue slots in the execute stage.
- Round-robin arbitration, valid/ready handshake on both sides.
- One registered output stage returns the result with the requester's tag and a source ID.
- Latency is one cycle from accept to `res_valid`.

Parameters:
- `XLEN`, 32, operand/result width
- `TAG_W`, 4, width of the opaque tag carried from request to result

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 accepted this cycle when `req0_valid` is also high
- `req0_s1`  in  XLEN  operand 1
- `req0_s2`  in  XLEN  operand 2
- `req0_op`  in  3  bit0 = and, bit1 = or, bit2 = xor
- `req0_tag`  in  TAG_W  tag returned with result
- `req1_valid`, `req1_ready`, `req1_s1`, `req1_s2`, `req1_op`, `req1_tag`: same as requester 0
- `res_valid`  out  1  result register holds a result
- `res_ready`  in  1  consumer takes result
- `res_data`  out  XLEN  result
- `res_tag`  out  TAG_W  tag of winning request
- `res_src`  out  1  0 = requester 0, 1 = requester 1

Behaviour:
- Reset (async assert, `rst_n` = 0):
  - `res_valid` = 0, `res_data` = 0, `res_tag` = 0, `res_src` = 0.
  - `last_grant` = 1, so requester 0 wins the first conflict.
  - Reset mid-transfer discards the held result; no result is emitted for it after reset release.
- Result computation, in priority order:
  - `op[0]` → s1 & s2
  - else `op[1]` → s1 | s2
  - else `op[2]` → s1 ^ s2
  - else 0
  - Multi-hot ops resolve by this priority; `op` = 000 yields 0 and is still a valid, accepted transaction.
- `can_accept` = !`res_valid` | `res_ready`.
- Grant:
  - Only req0 valid → grant 0.
  - Only req1 valid → grant 1.
  - Both valid → grant !`last_grant`.
  - Neither valid → no grant.
- `reqN_ready` = `can_accept` & (grant == N). This is combinational; it may depend on the other requester's valid. At most one ready is high per cycle.
- Accept: on a rising edge with `reqN_valid` & `reqN_ready`:
  - register `res_data`, `res_tag` and `res_src` = N;
  - set `res_valid` = 1 and `last_grant` = N.
- `last_grant` updates only on an accept; idle cycles do not rotate priority.
- Drain without accept (`res_valid` & `res_ready`, no new accept) → `res_valid` = 0. Data, tag and src hold their last values.
- Simultaneous drain and accept → new result loaded, `res_valid` stays 1. This gives full throughput of 1 op/cycle.
- Backpressure (`res_valid` & !`res_ready`):
  - Both readies are 0.
  - Result outputs stay stable until taken.
  - Pending requests are not reordered; arbitration re-evaluates each cycle.
- Requesters must hold valid, operands, op and tag stable until accepted. `res_*` outputs change only on clock edges.
- Fairness: with both requesters continuously valid and `res_ready` = 1, grants strictly alternate 0,1,0,1,…

Optional Feature:
- Macro: `LOGIC_ARB_STATS_EN`.
- When defined, adds ports:
  - `stat_grant0` out 16
  - `stat_grant1` out 16
  - `stat_conflict` out 16
- Counter behaviour:
  - `stat_grant0` / `stat_grant1` count accepts from requester 0 / 1.
  - `stat_conflict` counts cycles where both valids are high and `can_accept` is 1.
  - All counters saturate at 0xFFFF and reset to 0 on `rst_n` low.
- When undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset release, req0 only: s1 = 0xF0F0_F0F0, s2 = 0xFF00_FF00, op = 001, tag = 3 → next cycle `res_valid` = 1, `res_data` = 0xF000_F000, `res_tag` = 3, `res_src` = 0.
- Both valid continuously, `res_ready` = 1:
  - req0: op = 010, s1 = 0x1, s2 = 0x2.
  - req1: op = 100, s1 = 0xFF, s2 = 0x0F.
  - → results alternate 0x3 (src 0), 0xF0 (src 1), 0x3, …
  - First grant goes to req0; one result per cycle.
- Backpressure: `res_ready` = 0 for 3 cycles with a result held →
  - `res_data`/`res_tag` stable;
  - both readies 0;
  - on `res_ready` = 1, drain and new accept in the same cycle, `res_valid` stays 1.
- Op edges:
  - op = 000 → `res_data` = 0.
  - op = 111, s1 = 0xAAAA_AAAA, s2 = 0x5555_5555 → 0x0000_0000 (AND priority).
  - op = 110 → 0xFFFF_FFFF (OR).
- Async reset asserted while `res_valid` = 1 and `res_ready` = 0 → outputs clear immediately without a clock edge; after release, no stale result appears and the first conflict grants req0.
- With `LOGIC_ARB_STATS_EN`:
  - 10 cycles both-valid with `res_ready` = 1 → `stat_grant0` = 5, `stat_grant1` = 5, `stat_conflict` = 10.
  - Forced 70000 grants to req0 → `stat_grant0` = 0xFFFF.
